// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aluState_t;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per cycle.
// Product or {remainder, quotient} accumulates in {hiReg, loReg}.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             isDiv,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hiReg, loReg, operandReg;
    logic [CW-1:0]    countReg;
    logic             busyReg, divReg;
    logic [WIDTH:0]   addSum, trial;
    logic [WIDTH-1:0] hiStep, loStep;

    always_comb begin
        addSum = {1'b0, hiReg} + {1'b0, (loReg[0] ? operandReg : '0)};
        // Sign bit of the trial subtraction decides whether the divisor fits.
        trial  = {hiReg, loReg[WIDTH-1]} - {1'b0, operandReg};
        if (divReg) begin
            if (!trial[WIDTH]) begin
                hiStep = trial[WIDTH-1:0];
                loStep = {loReg[WIDTH-2:0], 1'b1};
            end else begin
                hiStep = {hiReg[WIDTH-2:0], loReg[WIDTH-1]};
                loStep = {loReg[WIDTH-2:0], 1'b0};
            end
        end else begin
            hiStep = addSum[WIDTH:1];
            loStep = {addSum[0], loReg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hiReg      <= '0;
            loReg      <= '0;
            operandReg <= '0;
            countReg   <= '0;
            busyReg    <= 1'b0;
            divReg     <= 1'b0;
        end else if (start) begin
            hiReg      <= '0;
            loReg      <= isDiv ? opA : opB;
            operandReg <= isDiv ? opB : opA;
            countReg   <= '0;
            busyReg    <= 1'b1;
            divReg     <= isDiv;
        end else if (busyReg) begin
            hiReg    <= hiStep;
            loReg    <= loStep;
            countReg <= countReg + 1'b1;
            if (countReg == CW'(WIDTH - 1)) begin
                busyReg <= 1'b0;
            end
        end
    end

    // The final step's outcome is presented combinationally so the top registers it on the same edge.
    assign done = busyReg && (countReg == CW'(WIDTH - 1));
    assign hi   = hiStep;
    assign lo   = loStep;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/valid handshake and registered results/flags.
// Define ALU_MULDIV_EN to include the iterative MUL/DIV unit and BUSY state.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             aluStart,
    input  logic [3:0]       aluControl,
    input  logic [WIDTH-1:0] aluInput1,
    input  logic [WIDTH-1:0] aluInput2,
    output logic             aluReady,
    output logic             aluValid,
    output logic [WIDTH-1:0] aluResult,
    output logic [WIDTH-1:0] aluResultHi,
    output logic             aluZero,
    output logic             aluOverflow,
    output logic             aluIllegal
);

    import alu_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    aluState_t        stateReg;
    logic             readyReg, validReg, zeroReg, overflowReg, illegalReg;
    logic [WIDTH-1:0] resultReg, resultHiReg;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sumVal, diffVal, opLo, opHi;
    logic             opOverflow, opIllegal, useIterative, accept;
    logic             mdDone;
    logic [WIDTH-1:0] mdHi, mdLo;

    always_comb begin
        shamt        = aluInput2[SHW-1:0];
        sumVal       = aluInput1 + aluInput2;
        diffVal      = aluInput1 - aluInput2;
        opLo         = '0;
        opHi         = '0;
        opOverflow   = 1'b0;
        opIllegal    = 1'b0;
        useIterative = 1'b0;
        case (aluControl)
            ALU_AND: opLo = aluInput1 & aluInput2;
            ALU_OR:  opLo = aluInput1 | aluInput2;
            ALU_ADD: begin
                opLo       = sumVal;
                opOverflow = (aluInput1[WIDTH-1] == aluInput2[WIDTH-1]) &&
                             (sumVal[WIDTH-1] != aluInput1[WIDTH-1]);
            end
            ALU_SUB: begin
                opLo       = diffVal;
                opOverflow = (aluInput1[WIDTH-1] != aluInput2[WIDTH-1]) &&
                             (diffVal[WIDTH-1] != aluInput1[WIDTH-1]);
            end
            ALU_SLL: opLo = aluInput1 << shamt;
            ALU_SRL: opLo = aluInput1 >> shamt;
            ALU_SLT: opLo = {{(WIDTH-1){1'b0}}, ($signed(aluInput1) < $signed(aluInput2))};
`ifdef ALU_MULDIV_EN
            ALU_MUL: useIterative = 1'b1;
            ALU_DIV: begin
                // Divide by zero resolves immediately without entering BUSY.
                if (aluInput2 == '0) begin
                    opLo = '1;
                    opHi = aluInput1;
                end else begin
                    useIterative = 1'b1;
                end
            end
`endif
            default: opIllegal = 1'b1;
        endcase
    end

    assign accept = aluStart && (stateReg == IDLE);

`ifdef ALU_MULDIV_EN
    alu_muldiv #(.WIDTH(WIDTH)) muldivUnit (
        .clock (clock),
        .reset (reset),
        .start (accept && useIterative),
        .isDiv (aluControl == ALU_DIV),
        .opA   (aluInput1),
        .opB   (aluInput2),
        .done  (mdDone),
        .hi    (mdHi),
        .lo    (mdLo)
    );
`else
    assign mdDone = 1'b0;
    assign mdHi   = '0;
    assign mdLo   = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg    <= IDLE;
            readyReg    <= 1'b1;
            validReg    <= 1'b0;
            resultReg   <= '0;
            resultHiReg <= '0;
            zeroReg     <= 1'b0;
            overflowReg <= 1'b0;
            illegalReg  <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (accept) begin
                        readyReg <= 1'b0;
                        if (useIterative) begin
                            stateReg <= BUSY;
                        end else begin
                            stateReg    <= DONE;
                            validReg    <= 1'b1;
                            resultReg   <= opLo;
                            resultHiReg <= opHi;
                            zeroReg     <= (opLo == '0);
                            overflowReg <= opOverflow;
                            illegalReg  <= opIllegal;
                        end
                    end
                end
                BUSY: begin
                    if (mdDone) begin
                        stateReg    <= DONE;
                        validReg    <= 1'b1;
                        resultReg   <= mdLo;
                        resultHiReg <= mdHi;
                        zeroReg     <= (mdLo == '0);
                        overflowReg <= 1'b0;
                        illegalReg  <= 1'b0;
                    end
                end
                DONE: begin
                    stateReg <= IDLE;
                    readyReg <= 1'b1;
                    validReg <= 1'b0;
                end
                default: begin
                    stateReg <= IDLE;
                    readyReg <= 1'b1;
                    validReg <= 1'b0;
                end
            endcase
        end
    end

    assign aluReady    = readyReg;
    assign aluValid    = validReg;
    assign aluResult   = resultReg;
    assign aluResultHi = resultHiReg;
    assign aluZero     = zeroReg;
    assign aluOverflow = overflowReg;
    assign aluIllegal  = illegalReg;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq against an arithmetic reference model.
// Expectations follow ALU_MULDIV_EN the same way the design does.
module tb_alu_seq;

    localparam int WIDTH = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic             clock = 1'b0;
    logic             reset;
    logic             aluStart;
    logic [3:0]       aluControl;
    logic [WIDTH-1:0] aluInput1, aluInput2;
    logic             aluReady, aluValid;
    logic [WIDTH-1:0] aluResult, aluResultHi;
    logic             aluZero, aluOverflow, aluIllegal;

    int testCount = 0;
    int failCount = 0;

    logic [3:0] opCodes [12] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'h3, 4'hF, 4'hA};

    always #5 clock = ~clock;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .aluStart    (aluStart),
        .aluControl  (aluControl),
        .aluInput1   (aluInput1),
        .aluInput2   (aluInput2),
        .aluReady    (aluReady),
        .aluValid    (aluValid),
        .aluResult   (aluResult),
        .aluResultHi (aluResultHi),
        .aluZero     (aluZero),
        .aluOverflow (aluOverflow),
        .aluIllegal  (aluIllegal)
    );

    task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic void refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] lo, output logic [31:0] hi,
                                     output logic ov, output logic ill, output int lat);
        longint sa, sb, s;
        logic [63:0] prod;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lo = '0; hi = '0; ov = 1'b0; ill = 1'b0; lat = 1;
        prod = '0;
        case (op)
            4'b0000: lo = a & b;
            4'b0001: lo = a | b;
            4'b0010: begin lo = a + b; s = sa + sb; ov = (s > SMAX) || (s < SMIN); end
            4'b0110: begin lo = a - b; s = sa - sb; ov = (s > SMAX) || (s < SMIN); end
            4'b0100: lo = a << (b % 32);
            4'b0101: lo = a >> (b % 32);
            4'b0111: lo = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_EN
            4'b1000: begin
                prod = 64'(a) * 64'(b);
                lo = prod[31:0];
                hi = prod[63:32];
                lat = WIDTH + 1;
            end
            4'b1001: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                    lat = WIDTH + 1;
                end
            end
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issues one operation starting on a negedge and checks the full transaction.
    task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] expLo, expHi;
        logic expOv, expIll;
        int expLat, lat, waitCount;
        refModel(op, a, b, expLo, expHi, expOv, expIll, expLat);
        waitCount = 0;
        while (!aluReady && waitCount < 100) begin
            @(negedge clock);
            waitCount++;
        end
        checkVal("ready_before", 64'(aluReady), 64'd1);
        aluControl = op;
        aluInput1  = a;
        aluInput2  = b;
        aluStart   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        aluStart = 1'b0;
        checkVal("ready_busy", 64'(aluReady), 64'd0);
        lat = 1;
        while (!aluValid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        checkVal("latency", 64'(lat), 64'(expLat));
        checkVal("result", 64'(aluResult), 64'(expLo));
        checkVal("result_hi", 64'(aluResultHi), 64'(expHi));
        checkVal("zero", 64'(aluZero), 64'(expLo == 0));
        checkVal("overflow", 64'(aluOverflow), 64'(expOv));
        checkVal("illegal", 64'(aluIllegal), 64'(expIll));
        $display("[TB] op=%b a=%h b=%h -> lo=%h hi=%h z=%0d ov=%0d ill=%0d lat=%0d",
                 op, a, b, aluResult, aluResultHi, aluZero, aluOverflow, aluIllegal, lat);
        @(negedge clock);
        checkVal("valid_pulse", 64'(aluValid), 64'd0);
        checkVal("ready_after", 64'(aluReady), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int validCount;
        logic [31:0] expLo, expHi;
        logic expOv, expIll;
        int expLat;

        reset      = 1'b1;
        aluStart   = 1'b0;
        aluControl = 4'h0;
        aluInput1  = '0;
        aluInput2  = '0;
        repeat (3) @(negedge clock);
        checkVal("rst_ready", 64'(aluReady), 64'd1);
        checkVal("rst_valid", 64'(aluValid), 64'd0);
        checkVal("rst_result", 64'(aluResult), 64'd0);
        checkVal("rst_result_hi", 64'(aluResultHi), 64'd0);
        checkVal("rst_flags", 64'({aluZero, aluOverflow, aluIllegal}), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        runOp(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        checkVal("add_ovf_const", 64'(aluResult), 64'h8000_0000);
        runOp(4'b0110, 32'd5, 32'd5);
        checkVal("sub_zero_const", 64'(aluZero), 64'd1);
        runOp(4'b0100, 32'h1, 32'd33);
        runOp(4'b0101, 32'h8000_0000, 32'd31);
        runOp(4'b0111, 32'hFFFF_FFFF, 32'h1);
        runOp(4'b0110, 32'h8000_0000, 32'h1);
        runOp(4'b1000, 32'hFFFF_FFFF, 32'h2);
        runOp(4'b1001, 32'd100, 32'd7);
        runOp(4'b1001, 32'd100, 32'd0);
        runOp(4'b0011, 32'h1234, 32'h5678);

        for (int i = 0; i < 30; i++) begin
            logic [3:0] op;
            logic [31:0] a, b;
            op = opCodes[$urandom_range(0, 11)];
            a  = pickOperand();
            b  = pickOperand();
            runOp(op, a, b);
        end

        // aluStart held high across a whole MUL must yield a single completion.
        refModel(4'b1000, 32'h0001_0003, 32'h0000_0101, expLo, expHi, expOv, expIll, expLat);
        aluControl = 4'b1000;
        aluInput1  = 32'h0001_0003;
        aluInput2  = 32'h0000_0101;
        aluStart   = 1'b1;
        validCount = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            if (aluValid) begin
                validCount++;
                checkVal("held_result", 64'(aluResult), 64'(expLo));
                aluStart = 1'b0;
            end
        end
        aluStart = 1'b0;
        checkVal("held_valid_count", 64'(validCount), 64'd1);
        $display("[TB] held-start MUL -> valid pulses=%0d", validCount);

        // Reset in the middle of a MUL aborts it with no completion.
        aluControl = 4'b1000;
        aluInput1  = 32'h0000_0123;
        aluInput2  = 32'h0000_0456;
        aluStart   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        aluStart = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        checkVal("abort_ready", 64'(aluReady), 64'd1);
        checkVal("abort_valid", 64'(aluValid), 64'd0);
        checkVal("abort_result", 64'(aluResult), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        validCount = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (aluValid) validCount++;
        end
        checkVal("abort_no_valid", 64'(validCount), 64'd0);
        checkVal("abort_ready_after", 64'(aluReady), 64'd1);
        $display("[TB] reset mid-MUL -> ready=%0d valid pulses=%0d", aluReady, validCount);

        runOp(4'b0001, 32'hF0F0_0000, 32'h0000_0F0F);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the datapath ALU. It adds a start/valid handshake, registered results and flags, right shifts and set-less-than, and an iterative unsigned multiply/divide producing a double-width result. It sits in the EX stage of the multi-cycle datapath; the control FSM issues one operation at a time and stalls until `aluValid`.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4 and a power of two.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `aluStart` in 1: request; accepted only on a rising edge where `aluReady`=1.
- `aluControl` in 4: operation code, captured at acceptance.
- `aluInput1`, `aluInput2` in WIDTH each: operands, captured at acceptance.
- `aluReady` out 1: block idle and able to accept.
- `aluValid` out 1: one-cycle pulse when the result is available.
- `aluResult` out WIDTH: result, or the low half for MUL, or the quotient for DIV.
- `aluResultHi` out WIDTH: high half for MUL, remainder for DIV, 0 for all other operations.
- `aluZero` out 1: `aluResult`==0. This is registered and does not look at `aluResultHi`.
- `aluOverflow` out 1: signed overflow of ADD/SUB; 0 for every other operation.
- `aluIllegal` out 1: the accepted code was unsupported.

## Operation
- Codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0100 SLL, 0101 SRL (logical), 0111 SLT (signed, result is 1 or 0).
  - 1000 MUL, unsigned, 2·WIDTH product.
  - 1001 DIV, unsigned.
  - All other codes are illegal.
- Shift amount is `aluInput2[$clog2(WIDTH)-1:0]`; upper bits are ignored.
- ADD/SUB wrap modulo 2^WIDTH.
- Overflow rule: operands of equal sign (ADD) or opposite sign (SUB) and a result sign differing from `aluInput1`.
- Illegal code: `aluResult`=0, `aluResultHi`=0, `aluIllegal`=1, completes as a single-cycle operation.
- DIV by zero: quotient all-ones, remainder = `aluInput1`, single-cycle latency, `aluIllegal`=0.
- FSM:
  - IDLE: `aluReady`=1. On accept, go to DONE for single-cycle operations, or to BUSY for MUL and for DIV with a non-zero divisor.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per cycle, WIDTH steps. Iteration counter 0..WIDTH-1; at WIDTH-1 go to DONE.
  - DONE: `aluValid`=1 for exactly one cycle, then IDLE.
- `aluStart` while `aluReady`=0 is ignored. It is not queued.
- Outputs hold their last values until the next operation completes. Only `aluValid` returns to 0.

## Timing
- Single-cycle operations: accept at edge N, `aluValid` high in cycle N+1, `aluReady` high again in cycle N+2.
- MUL and DIV (divisor ≠ 0): `aluValid` at N+WIDTH+1, i.e. N+33 for WIDTH=32.
- Reset values: `aluReady`=1. All other outputs are 0, state is IDLE, counter is 0.
- `reset` asserted mid-operation aborts immediately. No `aluValid` is produced for the aborted operation.
- Back-to-back issue: the earliest next accept is the cycle after `aluValid`, giving a throughput of one single-cycle operation per 2 cycles.
- All outputs are driven from registers; there is no combinational path from inputs to outputs.

## Configuration
- `ALU_MULDIV_EN` defined: MUL/DIV datapath and BUSY state are present, as described above.
- `ALU_MULDIV_EN` undefined:
  - Codes 1000 and 1001 are treated as illegal (`aluIllegal`=1, results 0, single-cycle latency).
  - BUSY, the counter and the iterative datapath are not synthesised.

## Structure
- Package `alu_pkg` holds:
  - The opcode localparams (`ALU_AND` … `ALU_DIV`).
  - The FSM state typedef (IDLE/BUSY/DONE).
- Sub-module `alu_muldiv` (WIDTH-parameterised) contains the iterative unit. Its interface:
  - Inputs: `start`, `isDiv`, operands.
  - Outputs: `done`, `hi`, `lo`.
  - It is instantiated only under `ALU_MULDIV_EN`.
- The top level contains the FSM, single-cycle ops, flag logic and output registers.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, zero 0, valid 1 cycle after accept.
- SUB 5 − 5 → result 0, zero 1, overflow 0.
- SLL 0x1 by 33 → 0x2; SRL 0x80000000 by 31 → 0x1; SLT −1 vs 1 → 1.
- MUL 0xFFFFFFFF × 2 → hi 0x1, lo 0xFFFFFFFE, valid at N+33.
- DIV 100 ÷ 7 → lo 14, hi 2, valid at N+33. DIV 100 ÷ 0 → lo 0xFFFFFFFF, hi 100, valid at N+1.
- Robustness cases:
  - `aluStart` held high through a MUL → exactly one `aluValid`.
  - `reset` at cycle 10 of a MUL → `aluReady` 1, no `aluValid`.
  - Code 1000 with `ALU_MULDIV_EN` undefined → `aluIllegal` 1, result 0, valid at N+1.
